// File: rtl/sprite_pkg.sv
// Shared types, default geometry and address helper for the sprite animation ROM.
package sprite_pkg;

    // Direction of travel through the ping-pong frame sequence.
    typedef enum logic [0:0] {
        FWD = 1'b0,
        BWD = 1'b1
    } anim_phase_t;

    // Default sprite geometry.
    localparam int SPR_W_DEF    = 16;
    localparam int SPR_H_DEF    = 16;
    localparam int BPP_DEF      = 2;
    localparam int N_DIR_DEF    = 4;
    localparam int N_FRAMES_DEF = 3;

    // Linear pixel address of (x, y) inside frame 'frame_i' of direction 'dir_i'.
    // Evaluated at 32 bits so no intermediate product can wrap.
    function automatic logic [31:0] sprite_addr(
        input logic [31:0] dir_i,
        input logic [31:0] frame_i,
        input logic [31:0] y_i,
        input logic [31:0] x_i,
        input logic [31:0] n_frames,
        input logic [31:0] spr_h,
        input logic [31:0] spr_w
    );
        return ((dir_i * n_frames + frame_i) * spr_h + y_i) * spr_w + x_i;
    endfunction

endpackage

// File: rtl/sprite_rom_core.sv
// Generic synchronous single-port ROM with registered output and read enable.
// The image for a named INIT_FILE is compiled in as a closed-form pattern;
// an empty INIT_FILE name yields an all-transparent (all-zero) image.
module sprite_rom_core
    import sprite_pkg::*;
#(
    parameter int    DEPTH     = 3072,
    parameter int    WIDTH     = 2,
    parameter string INIT_FILE = "sprite.mif",
    parameter int    AW        = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_addr,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q_valid
);

    localparam bit BLANK_IMAGE = (INIT_FILE == "");

    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;

    // Image content at address a: low bits of a + a/8 + a/128.
    function automatic logic [WIDTH-1:0] image_word(input logic [AW-1:0] a);
        logic [AW+1:0] s;
        s = (AW+2)'(a) + (AW+2)'(a >> 4'd3) + (AW+2)'(a >> 4'd7);
        return s[WIDTH-1:0];
    endfunction

    // Registered read port: data updates only on enabled reads, valid follows enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q       <= {WIDTH{1'b0}};
            r_q_valid <= 1'b0;
        end else begin
            r_q_valid <= i_rd_en;
            if (i_rd_en) begin
                r_q <= BLANK_IMAGE ? {WIDTH{1'b0}} : image_word(i_addr);
            end
        end
    end

    assign o_q       = r_q;
    assign o_q_valid = r_q_valid;

endmodule

// File: rtl/sprite_anim_rom.sv
// Multi-direction, multi-frame sprite ROM with ping-pong animation sequencer.
// Direction and frame changes commit only on frame_sync so a sprite never tears.
module sprite_anim_rom
    import sprite_pkg::*;
#(
    parameter int    SPR_W     = SPR_W_DEF,
    parameter int    SPR_H     = SPR_H_DEF,
    parameter int    BPP       = BPP_DEF,
    parameter int    N_DIR     = N_DIR_DEF,
    parameter int    N_FRAMES  = N_FRAMES_DEF,
    parameter string INIT_FILE = "sprite.mif"
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic                                              frame_sync,
    input  logic                                              anim_en,
    input  logic                                              anim_tick,
    input  logic [$clog2(N_DIR)-1:0]                          dir,
    input  logic                                              flip_h,
    input  logic                                              rd_en,
    input  logic [$clog2(SPR_W)-1:0]                          rd_x,
    input  logic [$clog2(SPR_H)-1:0]                          rd_y,
    output logic [BPP-1:0]                                    q,
    output logic                                              q_valid,
    output logic [((N_FRAMES > 1) ? $clog2(N_FRAMES) : 1)-1:0] frame_idx,
    output logic [$clog2(N_DIR)-1:0]                          dir_idx
);

    localparam int DW     = $clog2(N_DIR);
    localparam int FW     = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int XW     = $clog2(SPR_W);
    localparam int DEPTH  = N_DIR * N_FRAMES * SPR_W * SPR_H;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [FW-1:0] FRAME_ZERO = {FW{1'b0}};
    localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(N_FRAMES - 1);
    localparam logic [XW-1:0] X_MAX      = XW'(SPR_W - 1);

    logic [DW-1:0]     r_dir;
    logic [FW-1:0]     r_frame;
    anim_phase_t       r_phase;
    logic              r_tick_pending;

    logic [DW-1:0]     w_dir_nxt;
    logic [FW-1:0]     w_frame_nxt;
    anim_phase_t       w_phase_nxt;
    logic              w_tick_pending_nxt;

    logic [FW-1:0]     w_step_frame;
    anim_phase_t       w_step_phase;
    logic              w_tick_any;

    logic [XW-1:0]     w_x_eff;
    logic [ADDR_W-1:0] w_addr;

    assign w_tick_any = r_tick_pending | anim_tick;

    // One ping-pong step from the committed frame: 0,1,..,N-1,N-2,..,1,0,1,..
    always_comb begin
        w_step_frame = r_frame;
        w_step_phase = r_phase;
        if (N_FRAMES == 1) begin
            w_step_frame = FRAME_ZERO;
            w_step_phase = FWD;
        end else begin
            case (r_phase)
                FWD: begin
                    if (r_frame == FRAME_LAST) begin
                        w_step_frame = FW'(N_FRAMES - 2);
                        w_step_phase = BWD;
                    end else begin
                        w_step_frame = r_frame + FRAME_ONE;
                        w_step_phase = FWD;
                    end
                end
                BWD: begin
                    if (r_frame == FRAME_ZERO) begin
                        w_step_frame = FRAME_ONE;
                        w_step_phase = FWD;
                    end else begin
                        w_step_frame = r_frame - FRAME_ONE;
                        w_step_phase = BWD;
                    end
                end
                default: begin
                    w_step_frame = FRAME_ZERO;
                    w_step_phase = FWD;
                end
            endcase
        end
    end

    // Commit logic: direction change beats a frame step; ticks coalesce until a commit.
    always_comb begin
        w_dir_nxt          = r_dir;
        w_frame_nxt        = r_frame;
        w_phase_nxt        = r_phase;
        w_tick_pending_nxt = w_tick_any;
        if (frame_sync) begin
            if (dir != r_dir) begin
                w_dir_nxt          = dir;
                w_frame_nxt        = FRAME_ZERO;
                w_phase_nxt        = FWD;
                w_tick_pending_nxt = 1'b0;
            end else if (w_tick_any && anim_en) begin
                w_frame_nxt        = w_step_frame;
                w_phase_nxt        = w_step_phase;
                w_tick_pending_nxt = 1'b0;
            end else begin
                w_tick_pending_nxt = w_tick_any;
            end
        end else begin
            w_tick_pending_nxt = w_tick_any;
        end
    end

    // Sequencer state register (committed direction, frame, phase and pending tick).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dir          <= {DW{1'b0}};
            r_frame        <= FRAME_ZERO;
            r_phase        <= FWD;
            r_tick_pending <= 1'b0;
        end else begin
            r_dir          <= w_dir_nxt;
            r_frame        <= w_frame_nxt;
            r_phase        <= w_phase_nxt;
            r_tick_pending <= w_tick_pending_nxt;
        end
    end

    // Read address from the committed state of the issue cycle, with optional mirror.
    always_comb begin
        w_x_eff = rd_x;
        if (flip_h) begin
            w_x_eff = X_MAX - rd_x;
        end else begin
            w_x_eff = rd_x;
        end
        w_addr = ADDR_W'(sprite_addr(32'(r_dir), 32'(r_frame), 32'(rd_y), 32'(w_x_eff),
                                     32'(N_FRAMES), 32'(SPR_H), 32'(SPR_W)));
    end

    sprite_rom_core #(
        .DEPTH     (DEPTH),
        .WIDTH     (BPP),
        .INIT_FILE (INIT_FILE),
        .AW        (ADDR_W)
    ) u_rom (
        .clock     (clock),
        .reset     (reset),
        .i_rd_en   (rd_en),
        .i_addr    (w_addr),
        .o_q       (q),
        .o_q_valid (q_valid)
    );

    assign frame_idx = r_frame;
    assign dir_idx   = r_dir;

endmodule

// File: tb/tb_sprite_anim_rom.sv
// Directed, table-driven bench for sprite_anim_rom with default geometry.
module tb_sprite_anim_rom;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_sync;
    logic       anim_en;
    logic       anim_tick;
    logic [1:0] dir;
    logic       flip_h;
    logic       rd_en;
    logic [3:0] rd_x;
    logic [3:0] rd_y;
    logic [1:0] q;
    logic       q_valid;
    logic [1:0] frame_idx;
    logic [1:0] dir_idx;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       fs;
        logic       en;
        logic       tk;
        logic [1:0] d;
        logic       fl;
        logic       rd;
        logic [3:0] x;
        logic [3:0] y;
        int         ef;
        int         ed;
        logic       cq;
        int         ea;
    } vec_t;

    vec_t vecs[$];

    sprite_anim_rom #(
        .SPR_W(16), .SPR_H(16), .BPP(2), .N_DIR(4), .N_FRAMES(3), .INIT_FILE("sprite.mif")
    ) dut (
        .clock(clock), .reset(reset), .frame_sync(frame_sync), .anim_en(anim_en),
        .anim_tick(anim_tick), .dir(dir), .flip_h(flip_h), .rd_en(rd_en),
        .rd_x(rd_x), .rd_y(rd_y), .q(q), .q_valid(q_valid),
        .frame_idx(frame_idx), .dir_idx(dir_idx)
    );

    always #5 clock = ~clock;

    // Reference image: low two bits of a + a/8 + a/128.
    function automatic int img(input int a);
        int s;
        s = a + (a / 8) + (a / 128);
        return s % 4;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic fs, input logic en, input logic tk, input logic [1:0] d,
                       input logic fl, input logic rd, input logic [3:0] x, input logic [3:0] y,
                       input int ef, input int ed, input logic cq, input int ea);
        vec_t v;
        v.fs = fs; v.en = en; v.tk = tk; v.d = d; v.fl = fl; v.rd = rd;
        v.x = x; v.y = y; v.ef = ef; v.ed = ed; v.cq = cq; v.ea = ea;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; frame_sync = 1'b0; anim_en = 1'b1; anim_tick = 1'b0;
        dir = 2'd0; flip_h = 1'b0; rd_en = 1'b0; rd_x = 4'd0; rd_y = 4'd0;
        #2;
        step();
        step();
        reset = 1'b0;

        // Reset then idle.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_q", int'(q), 0);
            chk("idle_qv", int'(q_valid), 0);
            chk("idle_frame", int'(frame_idx), 0);
            chk("idle_dir", int'(dir_idx), 0);
        end

        // fs en tk dir fl rd x y | frame dir chk_q addr
        add(1,1,0,2, 0,1, 7, 1, 0,2, 1,  23); // commit dir 2; read uses old dir 0
        add(1,1,1,2, 0,1, 3, 5, 1,2, 1,1619); // frame 1; read uses dir2 frame0
        add(0,1,0,2, 0,1, 3, 5, 1,2, 1,1875);
        add(0,1,0,2, 1,1, 3, 5, 1,2, 1,1884); // flipped
        add(0,1,0,2, 0,0, 0, 0, 1,2, 1,1884); // q holds, q_valid drops
        // ping-pong from frame 1 FWD
        add(0,1,1,2, 0,0, 0, 0, 1,2, 0,   0);
        add(1,1,0,2, 0,0, 0, 0, 2,2, 0,   0);
        add(0,1,1,2, 0,0, 0, 0, 2,2, 0,   0);
        add(1,1,0,2, 0,0, 0, 0, 1,2, 0,   0);
        add(0,1,1,2, 0,0, 0, 0, 1,2, 0,   0);
        add(1,1,0,2, 0,0, 0, 0, 0,2, 0,   0);
        add(0,1,1,2, 0,1,15,15, 0,2, 1,1791);
        add(1,1,0,2, 0,0, 0, 0, 1,2, 0,   0);
        add(0,1,1,2, 0,0, 0, 0, 1,2, 0,   0);
        add(1,1,0,2, 0,0, 0, 0, 2,2, 0,   0);
        add(0,1,1,2, 0,0, 0, 0, 2,2, 0,   0);
        add(1,1,0,2, 0,0, 0, 0, 1,2, 0,   0);
        // coalescing: three ticks, one step
        add(0,1,1,2, 0,0, 0, 0, 1,2, 0,   0);
        add(0,1,1,2, 0,0, 0, 0, 1,2, 0,   0);
        add(0,1,1,2, 0,0, 0, 0, 1,2, 0,   0);
        add(0,1,0,2, 0,0, 0, 0, 1,2, 0,   0);
        add(1,1,0,2, 0,0, 0, 0, 0,2, 0,   0);
        add(1,1,0,2, 0,0, 0, 0, 0,2, 0,   0); // pending was cleared
        // anim_en=0 defers the pending tick
        add(0,1,1,2, 0,0, 0, 0, 0,2, 0,   0);
        add(1,0,0,2, 0,0, 0, 0, 0,2, 0,   0);
        add(1,0,0,2, 0,0, 0, 0, 0,2, 0,   0);
        add(1,1,0,2, 0,0, 0, 0, 1,2, 0,   0);
        add(0,1,1,2, 0,0, 0, 0, 1,2, 0,   0);
        add(1,1,0,2, 0,0, 0, 0, 2,2, 0,   0);
        // direction beats tick, tick discarded, then FWD from 0
        add(1,1,1,1, 0,0, 0, 0, 0,1, 0,   0);
        add(1,1,0,1, 0,0, 0, 0, 0,1, 0,   0);
        add(0,1,1,1, 0,0, 0, 0, 0,1, 0,   0);
        add(1,1,0,1, 0,0, 0, 0, 1,1, 0,   0);
        add(0,1,1,1, 0,0, 0, 0, 1,1, 0,   0);
        add(1,1,0,1, 0,0, 0, 0, 2,1, 0,   0);
        // dir glitch without frame_sync is ignored
        add(0,1,0,3, 0,1, 4, 9, 2,1, 1,1428);
        add(1,1,0,1, 0,0, 0, 0, 2,1, 0,   0);
        add(0,1,0,0, 0,0, 0, 0, 2,1, 0,   0);
        add(1,1,0,0, 0,0, 0, 0, 0,0, 0,   0);
        // back-to-back reads
        add(0,1,0,0, 1,1, 1, 0, 0,0, 1,  14);
        add(0,1,0,0, 1,1,15,15, 0,0, 1, 240);
        add(0,1,0,0, 0,1, 8, 2, 0,0, 1,  40);

        for (int i = 0; i < vecs.size(); i++) begin
            frame_sync = vecs[i].fs; anim_en = vecs[i].en; anim_tick = vecs[i].tk;
            dir = vecs[i].d; flip_h = vecs[i].fl; rd_en = vecs[i].rd;
            rd_x = vecs[i].x; rd_y = vecs[i].y;
            step();
            chk($sformatf("v%0d_frame", i), int'(frame_idx), vecs[i].ef);
            chk($sformatf("v%0d_dir", i), int'(dir_idx), vecs[i].ed);
            chk($sformatf("v%0d_qv", i), int'(q_valid), int'(vecs[i].rd));
            if (vecs[i].cq) begin
                chk($sformatf("v%0d_q", i), int'(q), img(vecs[i].ea));
            end
        end
        frame_sync = 1'b0; anim_tick = 1'b0; rd_en = 1'b0; flip_h = 1'b0; anim_en = 1'b1;

        // Reset mid-stream.
        dir = 2'd3; frame_sync = 1'b1;
        step();
        chk("rs_dir3", int'(dir_idx), 3);
        anim_tick = 1'b1;
        step();
        chk("rs_frame1", int'(frame_idx), 1);
        frame_sync = 1'b0; anim_tick = 1'b1; rd_en = 1'b1; rd_x = 4'd5; rd_y = 4'd3;
        step();
        chk("rs_pre_qv", int'(q_valid), 1);
        chk("rs_pre_q", int'(q), img(2613));
        anim_tick = 1'b0; reset = 1'b1;
        step();
        chk("rs_qv", int'(q_valid), 0);
        chk("rs_q", int'(q), 0);
        chk("rs_frame", int'(frame_idx), 0);
        chk("rs_dir", int'(dir_idx), 0);
        reset = 1'b0; dir = 2'd0;
        step();
        chk("rs_post_qv", int'(q_valid), 1);
        chk("rs_post_q", int'(q), img(53));
        rd_en = 1'b0; frame_sync = 1'b1;
        step();
        chk("rs_pending_cleared", int'(frame_idx), 0);
        chk("rs_post_idle_qv", int'(q_valid), 0);
        frame_sync = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
